// File: rtl/conv2d3x3s1.sv
// Streaming 3x3 stride-1 valid-padding convolution; `CONV_RELU_EN selects fused ReLU (unsigned out) vs signed saturation.
// Latency: 2 cycles from the accepting edge of the completing pixel to valid_out.
// Backpressure: none; one pixel per valid_in beat, gaps hold window state.
module conv2d3x3s1 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int SHIFT      = 7
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_load,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW + 1;
  localparam int SW = PW + 4;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

`ifdef CONV_RELU_EN
  localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** DW) - 1);
  localparam logic signed [SW-1:0] SAT_LO = '0;
`else
  localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-(2 ** (DW - 1)));
`endif

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [DW-1:0]          lb_top [IMG_WIDTH];
  logic [DW-1:0]          lb_mid [IMG_WIDTH];
  logic [DW-1:0]          win    [3][3];
  logic signed [DW-1:0]   wgt    [9];
  logic [3:0]             w_idx;
  tag_t                   win_tag;
  tag_t                   s1_tag;
  logic signed [SW-1:0]   s1_sum;
  logic signed [PW-1:0]   prod   [9];
  logic signed [SW-1:0]   acc;
  logic signed [SW-1:0]   shifted;
  logic signed [SW-1:0]   sat;
  logic                   col_last;
  logic                   row_last;
  logic                   idle;
  logic                   w_accept;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign idle     = (col == '0) && (row == '0) && !win_tag.vld && !s1_tag.vld;
  // A pixel in the same cycle wins over a weight beat.
  assign w_accept = w_load && !valid_in && idle;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      col <= col_last ? '0 : col + 1'b1;
      if (col_last) begin
        row <= row_last ? '0 : row + 1'b1;
      end
    end
  end

  // Line buffers are never read before being rewritten, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (valid_in) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= data_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      w_idx <= '0;
      for (int k = 0; k < 9; k++) begin
        wgt[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < 9; k++) begin
        if (w_idx == 4'(k)) begin
          wgt[k] <= w_data;
        end
      end
      w_idx <= (w_idx == 4'd8) ? '0 : w_idx + 4'd1;
    end
  end

  // Row 0 of the window is the oldest image row, column 2 the newest pixel.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      win_tag <= '0;
    end else begin
      if (valid_in) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb_top[col];
        win[1][2] <= lb_mid[col];
        win[2][2] <= data_in;
      end
      win_tag.vld  <= valid_in && (row >= RW'(2)) && (col >= CW'(2));
      win_tag.last <= valid_in && row_last && col_last;
    end
  end

  always_comb begin
    acc = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        prod[3*r+c] = $signed({{(PW-DW){1'b0}}, win[r][c]})
                    * $signed({{(PW-DW){wgt[3*r+c][DW-1]}}, wgt[3*r+c]});
        acc = acc + {{(SW-PW){prod[3*r+c][PW-1]}}, prod[3*r+c]};
      end
    end
  end

  always_comb begin
    shifted = s1_sum >>> SHIFT;
    sat     = shifted;
    if (shifted > SAT_HI) begin
      sat = SAT_HI;
    end else if (shifted < SAT_LO) begin
      sat = SAT_LO;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_tag     <= '0;
      s1_sum     <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      s1_tag <= win_tag;
      if (win_tag.vld) begin
        s1_sum <= acc;
      end
      valid_out  <= s1_tag.vld;
      frame_done <= s1_tag.vld && s1_tag.last;
      if (s1_tag.vld) begin
        data_out <= sat[DW-1:0];
      end
    end
  end

endmodule
